// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Two byte-stream requesters (0 = CPU store path, 1 = echo/debug path) share
// the UART transmitter's ready/valid input. A grant covers a whole message
// (up to the requester's last byte). It is also cut short after MAX_BURST beats,
// or after IDLE_TIMEOUT consecutive cycles in which the owner keeps valid low.
//
// Build option: define UART_ARB_FIXED_PRIO_EN to make requester 0 win every
// tie in IDLE and to drop the round-robin pointer. The default build uses
// round-robin: the requester just released becomes lowest priority.
//
// Handshake semantics (all three ports): a byte moves on a cycle where valid
// and ready are both high at the rising clock edge. Valid, data and last stay
// stable until that edge. Ready may change at any time, and last is only
// meaningful while valid is high.
module uart_tx_arbiter #(
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       timeout_pulse,
  output logic [1:0] dbg_state
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [SW-1:0] STALL_MAX = SW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          to_q, to_d;

  logic          own_valid;
  logic          own_last;
  logic          beat;
  logic [BW-1:0] beat_cnt_inc;
  logic [SW-1:0] stall_cnt_inc;
  logic          msg_done;
  logic          burst_done;
  logic          timed_out;
  logic          release_c;
  logic          pick0;
  logic          pick1;

  assign grant         = grant_q;
  assign timeout_pulse = to_q;
  assign dbg_state     = state_q;

  // Combinational pass-through of the owner's stream; nothing is buffered.
  always_comb begin
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    own_valid  = 1'b0;
    own_last   = 1'b0;
    case (state_q)
      ST_OWN0: begin
        tx_data    = req0_data;
        tx_valid   = req0_valid;
        req0_ready = tx_ready;
        own_valid  = req0_valid;
        own_last   = req0_last;
      end
      ST_OWN1: begin
        tx_data    = req1_data;
        tx_valid   = req1_valid;
        req1_ready = tx_ready;
        own_valid  = req1_valid;
        own_last   = req1_last;
      end
      default: begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
      end
    endcase
  end

  assign beat = tx_valid & tx_ready;

  // Release detection: message end, burst cap, or the owner stalling too long.
  // Backpressure (valid high, tx_ready low) is never counted as a stall.
  always_comb begin
    beat_cnt_inc  = beat ? (beat_cnt_q + BW'(1)) : beat_cnt_q;
    if (own_valid) begin
      stall_cnt_inc = '0;
    end else if (stall_cnt_q == STALL_MAX) begin
      stall_cnt_inc = stall_cnt_q;
    end else begin
      stall_cnt_inc = stall_cnt_q + SW'(1);
    end
    msg_done   = beat & own_last;
    burst_done = beat & (beat_cnt_inc == BURST_MAX);
    timed_out  = ~own_valid & (stall_cnt_inc == STALL_MAX);
    release_c  = (state_q != ST_IDLE) & (msg_done | burst_done | timed_out);
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  // Requester 0 always wins a tie; burst cap and timeout bound requester 1's wait.
  assign pick0 = req0_valid;
  assign pick1 = ~req0_valid & req1_valid;
`else
  logic rr_fav1_q, rr_fav1_d;

  // Round-robin: a tie goes to whichever requester the pointer favours.
  assign pick0 = req0_valid & (~req1_valid | ~rr_fav1_q);
  assign pick1 = req1_valid & (~req0_valid | rr_fav1_q);

  // The requester released this cycle becomes lowest priority.
  always_comb begin
    rr_fav1_d = rr_fav1_q;
    if (release_c) begin
      rr_fav1_d = (state_q == ST_OWN0);
    end
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_fav1_q <= 1'b0;
    end else begin
      rr_fav1_q <= rr_fav1_d;
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE and count beats/stalls while owned.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    to_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d  = '0;
        stall_cnt_d = '0;
        grant_d     = 2'b00;
        if (pick0) begin
          state_d = ST_OWN0;
          grant_d = 2'b01;
        end else if (pick1) begin
          state_d = ST_OWN1;
          grant_d = 2'b10;
        end
      end
      ST_OWN0, ST_OWN1: begin
        beat_cnt_d  = beat_cnt_inc;
        stall_cnt_d = stall_cnt_inc;
        if (release_c) begin
          state_d     = ST_IDLE;
          grant_d     = 2'b00;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
          to_d        = timed_out;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = 2'b00;
        beat_cnt_d  = '0;
        stall_cnt_d = '0;
      end
    endcase
  end

  // State, grant, counters and the timeout pulse; reset abandons any message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      to_q        <= to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (default parameters). A message-level
// model predicts ownership, the beat budget, stall timeouts and round-robin
// order. Per-requester expected byte queues catch dropped or duplicated bytes.
// Literal checks on the transmitted byte log pin the model.
// Build with +define+UART_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_uart_tx_arbiter;

  localparam int MAXB = 16;
  localparam int TMO  = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [1:0] grant;
  logic       timeout_pulse;
  logic [1:0] dbg_state;

  uart_tx_arbiter #(.MAX_BURST(MAXB), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .timeout_pulse(timeout_pulse), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] src0_d[$], src1_d[$];
  bit         src0_l[$], src1_l[$];
  logic [7:0] exp0_q[$], exp1_q[$];
  int         log_src[$];
  logic [7:0] log_dat[$];
  bit hs0 = 0, hs1 = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
  bit tog = 0;

  // Message-level model: who owns the port, how much of the burst is used,
  // how long the owner has been silent, and who wins the next tie.
  int m_own = -1;
  int m_beats = 0;
  int m_stall = 0;
  int m_fav = 0;
  bit m_to = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input bit l);
    if (r == 0) begin src0_d.push_back(d); src0_l.push_back(l); exp0_q.push_back(d); end
    else        begin src1_d.push_back(d); src1_l.push_back(l); exp1_q.push_back(d); end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    if (hs0 && src0_d.size() > 0) begin void'(src0_d.pop_front()); void'(src0_l.pop_front()); end
    if (hs1 && src1_d.size() > 0) begin void'(src1_d.pop_front()); void'(src1_l.pop_front()); end
    hs0 = 0;
    hs1 = 0;
    // With nothing to send, last is driven high as junk: it must be ignored.
    if (src0_d.size() > 0) begin req0_valid = 1; req0_data = src0_d[0]; req0_last = src0_l[0]; end
    else begin req0_valid = 0; req0_data = 8'hEE; req0_last = 1; end
    if (src1_d.size() > 0) begin req1_valid = 1; req1_data = src1_d[0]; req1_last = src1_l[0]; end
    else begin req1_valid = 0; req1_data = 8'hEE; req1_last = 1; end
    tog = ~tog;
    case (ready_mode)
      0: tx_ready = 1;
      1: tx_ready = tog;
      default: tx_ready = 0;
    endcase
  endtask

  // ---------------- per-cycle compare against the model ----------------
  task automatic model_check();
    logic [1:0] eg;
    bit vld, lst, beat, er0, er1;
    logic [7:0] ed, got;
    int bn, sn, w;
    if (!rst) begin
      chk("rst grant", grant, 2'b00);
      chk("rst tx_valid", tx_valid, 1'b0);
      chk("rst req0_ready", req0_ready, 1'b0);
      chk("rst req1_ready", req1_ready, 1'b0);
      chk("rst timeout_pulse", timeout_pulse, 1'b0);
      m_own = -1; m_beats = 0; m_stall = 0; m_fav = 0; m_to = 0;
      hs0 = 0; hs1 = 0;
      return;
    end
    eg  = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    vld = (m_own == 0) ? req0_valid : (m_own == 1) ? req1_valid : 1'b0;
    lst = (m_own == 0) ? req0_last  : (m_own == 1) ? req1_last  : 1'b0;
    ed  = (m_own == 0) ? req0_data  : req1_data;
    er0 = (m_own == 0) && tx_ready;
    er1 = (m_own == 1) && tx_ready;
    chk("grant", grant, eg);
    chk("timeout_pulse", timeout_pulse, m_to);
    chk("tx_valid", tx_valid, vld);
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    if (vld) chk("tx_data", tx_data, ed);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    beat = vld && tx_ready;
    if (beat) begin
      if (m_own == 0 && exp0_q.size() > 0) begin got = exp0_q.pop_front(); chk("sb byte req0", tx_data, got); end
      else if (m_own == 1 && exp1_q.size() > 0) begin got = exp1_q.pop_front(); chk("sb byte req1", tx_data, got); end
      else chk("sb unexpected byte", 1, 0);
      log_src.push_back(m_own);
      log_dat.push_back(tx_data);
    end
    // Advance the model to the next cycle.
    if (m_own < 0) begin
      m_to = 0;
      if (req0_valid || req1_valid) begin
`ifdef UART_ARB_FIXED_PRIO_EN
        w = req0_valid ? 0 : 1;
`else
        w = (req0_valid && req1_valid) ? m_fav : (req0_valid ? 0 : 1);
`endif
        m_own = w; m_beats = 0; m_stall = 0;
      end
    end else begin
      bn = m_beats + (beat ? 1 : 0);
      sn = vld ? 0 : m_stall + 1;
      m_to = 0;
      if ((beat && lst) || bn == MAXB || sn == TMO) begin
        m_to = (sn == TMO);
        m_fav = 1 - m_own;
        m_own = -1;
        bn = 0;
        sn = 0;
      end
      m_beats = bn;
      m_stall = sn;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    drive();
    cyc++;
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_done(input int limit, input string name);
    int i;
    bit done;
    i = 0;
    done = 0;
    while (i < limit && !done) begin
      adv();
      i++;
      done = (src0_d.size() == 0) && (src1_d.size() == 0) && (m_own < 0) &&
             (exp0_q.size() == 0) && (exp1_q.size() == 0);
    end
    chk(name, done, 1'b1);
    adv();
  endtask

  task automatic chk_log(input int idx, input int s, input logic [7:0] d);
    if (idx < log_dat.size()) begin
      chk("log owner", log_src[idx], s);
      chk("log byte", log_dat[idx], d);
    end else begin
      chk("log length", log_dat.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    rst = 0;
    src0_d.delete(); src1_d.delete(); src0_l.delete(); src1_l.delete();
    exp0_q.delete(); exp1_q.delete(); log_src.delete(); log_dat.delete();
    hs0 = 0; hs1 = 0; ready_mode = 0;
    repeat (3) adv();
    rst = 1;
    adv();
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int n;
    bit seen_to, r1_hi;
    logic [7:0] e2[8];

    // Reset values.
    adv();
    chk("reset grant", grant, 2'b00);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset readies", {req0_ready, req1_ready}, 2'b00);
    do_reset();

    // Single 3-byte message from requester 0.
    load(0, 8'h41, 0); load(0, 8'h42, 0); load(0, 8'h43, 1);
    adv();
    chk("t1 grant before", grant, 2'b00);
    adv();
    chk("t1 grant latency", grant, 2'b01);
    chk("t1 first byte", tx_data, 8'h41);
    adv(); adv(); adv();
    chk("t1 bubble tx_valid", tx_valid, 1'b0);
    chk("t1 bubble grant", grant, 2'b00);
    wait_done(20, "t1 done");
    chk_log(0, 0, 8'h41); chk_log(1, 0, 8'h42); chk_log(2, 0, 8'h43);

    // Both requesters with two 2-byte messages each.
    do_reset();
    load(0, 8'hA0, 0); load(0, 8'hA1, 1); load(0, 8'hB0, 0); load(0, 8'hB1, 1);
    load(1, 8'hC0, 0); load(1, 8'hC1, 1); load(1, 8'hD0, 0); load(1, 8'hD1, 1);
    wait_done(60, "t2 done");
`ifdef UART_ARB_FIXED_PRIO_EN
    e2[0] = 8'hA0; e2[1] = 8'hA1; e2[2] = 8'hB0; e2[3] = 8'hB1;
    e2[4] = 8'hC0; e2[5] = 8'hC1; e2[6] = 8'hD0; e2[7] = 8'hD1;
`else
    e2[0] = 8'hA0; e2[1] = 8'hA1; e2[2] = 8'hC0; e2[3] = 8'hC1;
    e2[4] = 8'hB0; e2[5] = 8'hB1; e2[6] = 8'hD0; e2[7] = 8'hD1;
`endif
    for (int i = 0; i < 8; i++) chk_log(i, (e2[i][6] ? 1 : 0), e2[i]);

    // Requester 1 streams 20 bytes; the burst cap cuts it at 16.
    do_reset();
    for (int i = 0; i < 20; i++) load(1, 8'h80 + 8'(i), (i == 19));
    adv(); adv();
    chk("t3 req1 granted", grant, 2'b10);
    load(0, 8'h10, 0); load(0, 8'h11, 1);
    wait_done(100, "t3 done");
    chk_log(15, 1, 8'h8F);
    chk_log(16, 0, 8'h10);
    chk_log(17, 0, 8'h11);
    chk_log(18, 1, 8'h90);
    chk_log(21, 1, 8'h93);

    // Owner stalls after one byte: forced release after the timeout.
    do_reset();
    load(0, 8'h55, 0);
    n = 0;
    while (!hs0 && n < 10) begin adv(); n++; end
    chk("t4 first beat seen", hs0, 1'b1);
    n = 0;
    while (n < 1100) begin
      adv();
      n++;
      if (timeout_pulse) break;
    end
    chk("t4 cycles to timeout", n, 1025);
    chk("t4 grant after timeout", grant, 2'b00);
    adv();
    chk("t4 pulse one cycle", timeout_pulse, 1'b0);

    // UART backpressure for 5000 cycles never times out.
    ready_mode = 2;
    load(0, 8'h66, 1);
    seen_to = 0;
    for (int i = 0; i < 5000; i++) begin
      adv();
      if (timeout_pulse) seen_to = 1;
    end
    chk("t4 backpressure grant", grant, 2'b01);
    chk("t4 backpressure no timeout", seen_to, 1'b0);
    ready_mode = 0;
    wait_done(10, "t4 done");
    chk_log(1, 0, 8'h66);

    // tx_ready toggling during a 5-byte message.
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 5; i++) load(0, 8'h20 + 8'(i), (i == 4));
    adv(); adv();
    load(1, 8'h30, 1);
    r1_hi = 0;
    n = 0;
    while (n < 40 && exp0_q.size() > 0) begin
      adv();
      n++;
      if (grant == 2'b01 && req1_ready) r1_hi = 1;
    end
    chk("t5 req1_ready low", r1_hi, 1'b0);
    wait_done(40, "t5 done");
    for (int i = 0; i < 5; i++) chk_log(i, 0, 8'h20 + 8'(i));
    chk_log(5, 1, 8'h30);
    chk("t5 log length", log_dat.size(), 6);

    // Reset asserted in the middle of an OWN0 message.
    do_reset();
    load(0, 8'h70, 0); load(0, 8'h71, 0); load(0, 8'h72, 0); load(0, 8'h73, 1);
    adv(); adv();
    chk("t6 owned before reset", grant, 2'b01);
    rst = 0;
    #1;
    chk("t6 async grant", grant, 2'b00);
    chk("t6 async tx_valid", tx_valid, 1'b0);
    chk("t6 async readies", {req0_ready, req1_ready}, 2'b00);
    src0_d.delete(); src0_l.delete(); exp0_q.delete();
    hs0 = 0;
    log_src.delete(); log_dat.delete();
    adv(); adv();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      adv();
      chk("t6 no byte after reset", tx_valid, 1'b0);
    end
    load(1, 8'h99, 1);
    wait_done(20, "t6 done");
    chk_log(0, 1, 8'h99);
    chk("t6 log length", log_dat.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Arbitrates two byte-stream requesters (CPU memory-mapped UART store path and the hardware echo/debug path) onto the single ready/valid transmit interface of the on-chip UART. Grants are held for a whole message (until the requester flags its last byte), capped at a maximum burst length and released early if the owner stalls. Sits between the requesters and the UART transmitter inside `riscv`, in the `clk` domain.

## Interface
- `MAX_BURST`, 16: maximum bytes per grant; must be ≥1.
- `IDLE_TIMEOUT`, 1024: cycles an owner may hold `valid` low mid-grant before forced release; must be ≥1.
- `clk`  in  1  system clock (`CPU_CLOCK_FREQ`).
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-low.**
- `req0_data`  in  8  requester 0 byte (CPU path).
- `req0_valid`  in  1  requester 0 byte valid.
- `req0_last`  in  1  qualifies `req0_data` as final byte of message.
- `req0_ready`  out  1  requester 0 byte accepted when high with `req0_valid`.
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: same for requester 1 (echo path).
- `tx_data`  out  8  byte to UART transmitter.
- `tx_valid`  out  1  byte valid to UART transmitter.
- `tx_ready`  in  1  UART transmitter can accept.
- `grant`  out  2  one-hot current owner; 0 = none.
- `timeout_pulse`  out  1  one-cycle pulse on forced release by timeout.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE: all readies 0, `tx_valid`=0. If any `reqN_valid`, register winner and go to OWNN next cycle. Both valid: winner per priority policy (see Configuration).
- OWNN: `tx_data`=`reqN_data`, `tx_valid`=`reqN_valid`, `reqN_ready`=`tx_ready`; other requester's ready held 0. Combinational pass-through, no data buffering.
- Beat = `tx_valid & tx_ready`. Beat counter increments per beat, cleared on entering IDLE; width `$clog2(MAX_BURST+1)`.
- Release to IDLE at end of the cycle in which: beat with `reqN_last`=1; or beat count reaches `MAX_BURST`; or stall counter reaches `IDLE_TIMEOUT`.
- Stall counter: counts cycles in OWNN with `reqN_valid`=0; cleared on any cycle with `reqN_valid`=1 and on entering IDLE; saturating. Cycles with `valid`=1, `tx_ready`=0 are not stalls (UART backpressure never times out).
- Round-robin pointer: on release from OWNN, requester N becomes lowest priority.
- `last` without `valid` is ignored.

## Timing
- Arbitration latency: `valid` seen in IDLE in cycle t → `grant`, `tx_valid` in cycle t+1.
- Every release costs one IDLE bubble cycle; back-to-back messages from the same requester are separated by ≥1 cycle of `tx_valid`=0.
- `tx_valid`/`tx_data`/readies are combinational from inputs in OWN states; `grant` and `timeout_pulse` are registered.
- `timeout_pulse` high the first IDLE cycle after a timeout release only.
- Reset (asynchronous assert, synchronous deassert handled upstream): state IDLE, `grant`=0, `tx_valid`=0, both readies 0, `timeout_pulse`=0, counters 0, pointer favours requester 0. Reset mid-burst abandons the message; no byte emitted after reset asserts.
- Simultaneous release and new request: request evaluated in the following IDLE cycle with updated pointer.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: requester 0 always wins ties in IDLE; pointer logic removed. Burst cap and timeout still apply (bounds starvation of requester 1).
- Undefined (default): round-robin as above.

## Test plan
- Reset → `grant`=0, `tx_valid`=0, `req0_ready`=`req1_ready`=0; assert `rst`=0 mid-OWN0 → same values immediately, no further `tx_valid`.
- req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), `tx_ready`=1 → `grant`=01 one cycle after first valid, tx stream 0x41,0x42,0x43, then IDLE bubble.
- Both requesters valid from reset, each 2-byte messages, round-robin build → order req0 msg, req1 msg, req0 msg; with `UART_ARB_FIXED_PRIO_EN` → req0 msgs until req0 idle.
- req1 streams 20 bytes with no `last`, MAX_BURST=16 → release after 16th beat, req0 (pending) granted next, req1 resumes later with byte 17.
- req0 granted, sends 1 byte then drops `valid` 1024 cycles → `timeout_pulse` for one cycle, `grant`=0; `tx_ready`=0 for 5000 cycles with `valid`=1 → no timeout.
- `tx_ready` toggling every other cycle during req0 5-byte message → each byte appears exactly once, `req1_ready` stays 0 throughout.
